dump_window_ctrl: RTL and testbench
===================================

# dump_window_ctrl

Synthesizable scheduler for the simulation/debug signal-dump window in the game test harness. It counts video frames on falling edges of vertical sync and opens a capture window in one of two ways: at a programmed frame number, or when a ROM download finishes. The window closes after a programmed number of frames. Its outputs drive the bench's dump on/off hooks and can also gate an on-chip trace buffer.

## Interface
- CNTW, 32, frame counter width
- LENW, 16, capture-length width
- MIN_LOAD_CYCLES, 20000, clk cycles after reset before a download-end edge is honoured
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- vs  in  1  vertical sync, synchronous to clk; frame boundary = falling edge
- downloading  in  1  ROM download in progress; falling edge = download end
- arm  in  1  level; 1 = run scheduler, 0 = abort/return to IDLE
- cfg_wait_load  in  1  1 = trigger on download end, 0 = trigger on frame match
- cfg_start_frame  in  CNTW  frame number that opens the window
- cfg_len  in  LENW  window length in frames; 0 = unbounded
- frame_cnt  out  CNTW  frames seen since reset
- dump_en  out  1  capture window open
- dump_start  out  1  one-cycle pulse on window open
- dump_stop  out  1  one-cycle pulse on window close
- done  out  1  window completed; held until arm drops

## Operation
- Edge detect: vs_l and dl_l are registered copies, reset to 0, so no false edge follows reset. vs_fall = vs_l & ~vs; dl_fall = dl_l & ~downloading.
- frame_cnt: +1 on every vs_fall in all states; wraps from 2^CNTW-1 to 0. Comparisons use the value before the increment.
- ld_cnt: counts clk cycles from reset and saturates at MIN_LOAD_CYCLES. load_ok = (ld_cnt == MIN_LOAD_CYCLES).
- Config latch: cfg_* are captured when leaving IDLE. Later changes are ignored until the next IDLE exit.
- FSM states and transitions:
  - IDLE: when arm=1, go to WAIT_LOAD if cfg_wait_load=1, else go to ARMED.
  - WAIT_LOAD: when dl_fall & load_ok, go to CAPTURE. A dl_fall while load_ok=0 is discarded.
  - ARMED: when vs_fall & frame_cnt==start_l, go to CAPTURE.
  - CAPTURE: on entry cap_cnt=0. Each vs_fall increments cap_cnt. When vs_fall & len_l!=0 & cap_cnt==len_l-1, go to DONE.
  - DONE: done=1. When arm=0, go to IDLE.
  - Any state with arm=0: go to IDLE. Abort takes priority over every other transition.
- dump_en = (state==CAPTURE), registered.
- dump_start pulses on the cycle dump_en first reads 1.
- dump_stop pulses on the cycle dump_en first reads 0 after CAPTURE. This covers both a DONE exit and an abort.
- cap_cnt is LENW bits. The unbounded mode (len 0) never compares, so no wrap issue arises.

## Timing
- Reset values: frame_cnt=0, dump_en=0, dump_start=0, dump_stop=0, done=0, state=IDLE, ld_cnt=0.
- Edge latency: if vs is first sampled low at edge k, frame_cnt and state update at edge k. Outputs are valid from edge k onward.
- Window length: with cfg_len=N>0, dump_en stays high from the opening vs_fall edge until the Nth following vs_fall edge, i.e. exactly N frames.
- Coincident events: a vs_fall that opens the window also increments frame_cnt, but it does not count as a captured frame.
- dl_fall and vs_fall in the same cycle while in WAIT_LOAD: enter CAPTURE. That vs_fall is not counted.
- arm=0 in the same cycle as a closing vs_fall: go to IDLE with done=0. dump_stop still pulses once.
- rst asserted mid-CAPTURE: all outputs return to reset values at the next edge. No dump_stop pulse.

## Structure
- Package dump_ctrl_pkg holds:
  - the state enum, one-hot encoded: IDLE, WAIT_LOAD, ARMED, CAPTURE, DONE
  - the default widths for CNTW and LENW
- Sub-module dump_fall_det (register plus falling-edge pulse, reset to 0), instanced for vs and downloading.

## Test plan
- Frame trigger: cfg_wait_load=0, start=3, len=2, arm=1, 8 vs pulses.
  - dump_start at the vs_fall where frame_cnt=3.
  - dump_en high until the vs_fall where frame_cnt=5.
  - dump_stop pulses once; done=1.
- Load trigger: cfg_wait_load=1, MIN_LOAD_CYCLES=100.
  - downloading falls at cycle 50: ignored.
  - downloading falls again at cycle 300: dump_start one cycle later, on the sampling edge.
- Unbounded window: len=0, start=0. dump_en stays high across 20 frames. Dropping arm gives one dump_stop pulse, then IDLE.
- Wrap: CNTW=4, start=15.
  - Window opens at frame_cnt=15; the next frame_cnt is 0.
  - With re-arm and start=0, the window opens after 16 more frames.
- Abort/reset: arm drops mid-CAPTURE, giving dump_stop and done=0. A second run asserts rst mid-CAPTURE: all outputs 0 next cycle, no dump_stop pulse.
- Config latch: change cfg_start_frame from 3 to 6 while ARMED. The window still opens at frame 3.

Source files
------------

// File: rtl/dump_ctrl_pkg.sv
// Shared types and default widths for the dump-window scheduler.
package dump_ctrl_pkg;

    localparam int CNTW_DEF     = 32;
    localparam int LENW_DEF     = 16;
    localparam int MIN_LOAD_DEF = 20000;

    // One-hot scheduler states.
    typedef enum logic [4:0] {
        ST_IDLE      = 5'b00001,
        ST_WAIT_LOAD = 5'b00010,
        ST_ARMED     = 5'b00100,
        ST_CAPTURE   = 5'b01000,
        ST_DONE      = 5'b10000
    } dump_state_e;

endpackage

// File: rtl/dump_fall_det.sv
// Registered copy of a clk-synchronous level plus a falling-edge pulse.
// The copy resets to 0, so a signal that is low out of reset never
// produces a spurious edge.
module dump_fall_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic fall_o
);

    logic sig_q;

    // Delay the level by one clock to compare against the live value.
    always_ff @(posedge clk) begin
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig_i;
    end

    assign fall_o = sig_q & ~sig_i;

endmodule

// File: rtl/dump_window_ctrl.sv
// Capture-window scheduler: counts frames on vs falling edges and opens a
// dump window either at a programmed frame number or at the end of a ROM
// download, closing it after a programmed number of frames.
module dump_window_ctrl
    import dump_ctrl_pkg::*;
#(
    parameter int CNTW            = CNTW_DEF,
    parameter int LENW            = LENW_DEF,
    parameter int MIN_LOAD_CYCLES = MIN_LOAD_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vs,
    input  logic            downloading,
    input  logic            arm,
    input  logic            cfg_wait_load,
    input  logic [CNTW-1:0] cfg_start_frame,
    input  logic [LENW-1:0] cfg_len,
    output logic [CNTW-1:0] frame_cnt,
    output logic            dump_en,
    output logic            dump_start,
    output logic            dump_stop,
    output logic            done
);

    // +2 keeps the width at least 1 even when MIN_LOAD_CYCLES is 0.
    localparam int             LDW    = $clog2(MIN_LOAD_CYCLES + 2);
    localparam logic [LDW-1:0] LD_MAX = LDW'(MIN_LOAD_CYCLES);

    logic vs_fall;
    logic dl_fall;

    dump_fall_det u_vs_det (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (vs),
        .fall_o (vs_fall)
    );

    dump_fall_det u_dl_det (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (downloading),
        .fall_o (dl_fall)
    );

    logic [CNTW-1:0] frame_cnt_q;
    logic [LDW-1:0]  ld_cnt_q;
    logic            load_ok;

    dump_state_e     state_q, state_d;
    logic [LENW-1:0] cap_cnt_q, cap_cnt_d;
    logic [CNTW-1:0] start_q, start_d;
    logic [LENW-1:0] len_q, len_d;

    logic dump_en_q, dump_start_q, dump_stop_q, done_q;
    logic in_cap_d, was_cap, cap_close;

    // Free-running frame counter; wraps naturally at 2^CNTW.
    always_ff @(posedge clk) begin
        if (rst)          frame_cnt_q <= '0;
        else if (vs_fall) frame_cnt_q <= frame_cnt_q + CNTW'(1);
    end

    // Post-reset settle counter; download-end edges before it saturates
    // are the power-on glitch of the loader and are ignored.
    always_ff @(posedge clk) begin
        if (rst)           ld_cnt_q <= '0;
        else if (!load_ok) ld_cnt_q <= ld_cnt_q + LDW'(1);
    end

    assign load_ok   = (ld_cnt_q == LD_MAX);
    assign cap_close = vs_fall && (len_q != '0) && (cap_cnt_q == len_q - LENW'(1));

    // Next-state logic; arm low overrides every other transition.
    always_comb begin
        state_d   = state_q;
        cap_cnt_d = cap_cnt_q;
        start_d   = start_q;
        len_d     = len_q;
        if (!arm) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    start_d = cfg_start_frame;
                    len_d   = cfg_len;
                    state_d = cfg_wait_load ? ST_WAIT_LOAD : ST_ARMED;
                end
                ST_WAIT_LOAD: begin
                    if (dl_fall && load_ok) begin
                        state_d   = ST_CAPTURE;
                        cap_cnt_d = '0;
                    end
                end
                ST_ARMED: begin
                    if (vs_fall && (frame_cnt_q == start_q)) begin
                        state_d   = ST_CAPTURE;
                        cap_cnt_d = '0;
                    end
                end
                ST_CAPTURE: begin
                    if (vs_fall) cap_cnt_d = cap_cnt_q + LENW'(1);
                    if (cap_close) state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign in_cap_d = (state_d == ST_CAPTURE);
    assign was_cap  = (state_q == ST_CAPTURE);

    // State, latched config and capture counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cap_cnt_q <= '0;
            start_q   <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            cap_cnt_q <= cap_cnt_d;
            start_q   <= start_d;
            len_q     <= len_d;
        end
    end

    // Registered outputs; start/stop pulses coincide with dump_en edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            dump_en_q    <= 1'b0;
            dump_start_q <= 1'b0;
            dump_stop_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            dump_en_q    <= in_cap_d;
            dump_start_q <= in_cap_d & ~was_cap;
            dump_stop_q  <= was_cap & ~in_cap_d;
            done_q       <= (state_d == ST_DONE);
        end
    end

    assign frame_cnt  = frame_cnt_q;
    assign dump_en    = dump_en_q;
    assign dump_start = dump_start_q;
    assign dump_stop  = dump_stop_q;
    assign done       = done_q;

endmodule

// File: tb/tb_dump_window_ctrl.sv
// Bench for dump_window_ctrl: directed scenarios plus random stimulus,
// all checked cycle by cycle against a frame/window-level reference model.
module tb_dump_window_ctrl;

    localparam int CNTW = 4;
    localparam int LENW = 8;
    localparam int MINL = 100;

    logic            clk = 1'b0;
    logic            r_rst = 1'b1, r_vs = 1'b0, r_dl = 1'b0, r_arm = 1'b0, r_wl = 1'b0;
    logic [CNTW-1:0] r_sf = '0;
    logic [LENW-1:0] r_len = '0;
    logic [CNTW-1:0] frame_cnt;
    logic            dump_en, dump_start, dump_stop, done;

    dump_window_ctrl #(.CNTW(CNTW), .LENW(LENW), .MIN_LOAD_CYCLES(MINL)) dut (
        .clk             (clk),
        .rst             (r_rst),
        .vs              (r_vs),
        .downloading     (r_dl),
        .arm             (r_arm),
        .cfg_wait_load   (r_wl),
        .cfg_start_frame (r_sf),
        .cfg_len         (r_len),
        .frame_cnt       (frame_cnt),
        .dump_en         (dump_en),
        .dump_start      (dump_start),
        .dump_stop       (dump_stop),
        .done            (done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int st_cnt = 0, sp_cnt = 0;
    int fc_at_start = -1, fc_at_stop = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phases of a capture run, frames seen, frames captured.
    localparam int M_IDLE = 0, M_WAIT = 1, M_ARMED = 2, M_CAP = 3, M_DONE = 4;
    int m_phase = M_IDLE, m_frames = 0, m_edges = 0, m_start = 0, m_len = 0, m_captured = 0;
    bit m_vs_prev = 0, m_dl_prev = 0;
    bit m_en = 0, m_sp = 0, m_ep = 0, m_done = 0;

    task automatic model_step();
        bit vsf, dlf, ld_ok, was;
        if (r_rst) begin
            m_phase = M_IDLE; m_frames = 0; m_edges = 0; m_captured = 0;
            m_start = 0; m_len = 0;
            m_vs_prev = 0; m_dl_prev = 0;
            m_en = 0; m_sp = 0; m_ep = 0; m_done = 0;
            return;
        end
        vsf   = m_vs_prev && !r_vs;
        dlf   = m_dl_prev && !r_dl;
        ld_ok = (m_edges >= MINL);
        was   = (m_phase == M_CAP);
        if (!r_arm) m_phase = M_IDLE;
        else if (m_phase == M_IDLE) begin
            m_start = int'(r_sf); m_len = int'(r_len);
            m_phase = r_wl ? M_WAIT : M_ARMED;
        end else if (m_phase == M_WAIT) begin
            if (dlf && ld_ok) begin m_phase = M_CAP; m_captured = 0; end
        end else if (m_phase == M_ARMED) begin
            if (vsf && m_frames == m_start) begin m_phase = M_CAP; m_captured = 0; end
        end else if (m_phase == M_CAP) begin
            if (vsf) begin
                m_captured++;
                if (m_len != 0 && m_captured == m_len) m_phase = M_DONE;
            end
        end
        if (vsf) m_frames = (m_frames + 1) % (1 << CNTW);
        m_edges++;
        m_en   = (m_phase == M_CAP);
        m_sp   = m_en && !was;
        m_ep   = was && !m_en;
        m_done = (m_phase == M_DONE);
        m_vs_prev = r_vs;
        m_dl_prev = r_dl;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk); #1;
        chk("frame_cnt",  32'(frame_cnt),  32'(m_frames));
        chk("dump_en",    32'(dump_en),    32'(m_en));
        chk("dump_start", 32'(dump_start), 32'(m_sp));
        chk("dump_stop",  32'(dump_stop),  32'(m_ep));
        chk("done",       32'(done),       32'(m_done));
        if (dump_start) begin st_cnt++; fc_at_start = int'(frame_cnt); end
        if (dump_stop)  begin sp_cnt++; fc_at_stop  = int'(frame_cnt); end
    endtask

    task automatic frame();
        r_vs = 1'b1; cyc(); cyc();
        r_vs = 1'b0; cyc(); cyc();
    endtask

    task automatic do_reset();
        r_rst = 1'b1; r_arm = 1'b0; r_vs = 1'b0; r_dl = 1'b0;
        cyc(); cyc();
        r_rst = 1'b0;
        st_cnt = 0; sp_cnt = 0; fc_at_start = -1; fc_at_stop = -1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_fc", 32'(frame_cnt), 0);
        chk("rst_en", 32'(dump_en), 0);
        chk("rst_done", 32'(done), 0);

        // Frame trigger with config change while armed
        r_wl = 0; r_sf = 4'd3; r_len = 8'd2; r_arm = 1;
        cyc();
        r_sf = 4'd6;
        for (int i = 0; i < 8; i++) frame();
        chk("ft_starts", st_cnt, 1);
        chk("ft_stops", sp_cnt, 1);
        chk("ft_open_fc", fc_at_start, 4);
        chk("ft_close_fc", fc_at_stop, 6);
        chk("ft_done", 32'(done), 1);
        r_arm = 0; cyc();
        chk("ft_done_clr", 32'(done), 0);

        // Load trigger: early download end is ignored
        do_reset();
        r_wl = 1; r_len = 8'd3; r_arm = 1; r_dl = 1;
        for (int c = 1; c < 50; c++) cyc();
        r_dl = 0; cyc(); cyc();
        r_dl = 1;
        for (int c = 52; c < 300; c++) cyc();
        chk("ld_early_ignored", st_cnt, 0);
        r_dl = 0; cyc();
        chk("ld_open", 32'(dump_start), 1);
        for (int i = 0; i < 4; i++) frame();
        chk("ld_done", 32'(done), 1);
        r_arm = 0; cyc();

        // Unbounded window
        do_reset();
        r_wl = 0; r_sf = 4'd0; r_len = 8'd0; r_arm = 1;
        cyc();
        for (int i = 0; i < 21; i++) frame();
        chk("ub_en", 32'(dump_en), 1);
        chk("ub_nostop", sp_cnt, 0);
        r_arm = 0; cyc(); cyc();
        chk("ub_stops", sp_cnt, 1);

        // Counter wrap
        do_reset();
        r_sf = 4'd15; r_len = 8'd1; r_arm = 1;
        cyc();
        for (int i = 0; i < 16; i++) frame();
        chk("wr_open_fc", fc_at_start, 0);
        frame();
        chk("wr_done", 32'(done), 1);
        r_arm = 0; cyc();
        r_sf = 4'd0; r_arm = 1; st_cnt = 0;
        cyc();
        for (int i = 0; i < 15; i++) frame();
        chk("wr_not_yet", st_cnt, 0);
        frame();
        chk("wr_reopen", st_cnt, 1);
        chk("wr_reopen_en", 32'(dump_en), 1);
        r_arm = 0; cyc();

        // Abort mid-capture, then reset mid-capture
        do_reset();
        r_sf = 4'd1; r_len = 8'd5; r_arm = 1;
        cyc();
        for (int i = 0; i < 3; i++) frame();
        r_arm = 0; cyc();
        chk("ab_stop", sp_cnt, 1);
        chk("ab_done", 32'(done), 0);
        r_sf = 4'd4; r_arm = 1; sp_cnt = 0;
        cyc();
        for (int i = 0; i < 3; i++) frame();
        chk("rc_in_cap", 32'(dump_en), 1);
        r_rst = 1; cyc();
        chk("rc_en", 32'(dump_en), 0);
        chk("rc_fc", 32'(frame_cnt), 0);
        chk("rc_nostop", sp_cnt, 0);
        r_rst = 0; r_arm = 0; cyc();
        chk("rc_nostop2", sp_cnt, 0);

        // Random stimulus
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            r_rst = ($urandom_range(699) == 0);
            if ($urandom_range(3) == 0)  r_vs = ~r_vs;
            if ($urandom_range(63) == 0) r_dl = ~r_dl;
            if (r_arm) r_arm = ($urandom_range(149) != 0);
            else       r_arm = ($urandom_range(3) == 0);
            if ($urandom_range(7) == 0) begin
                r_wl  = 1'($urandom_range(1));
                r_sf  = 4'($urandom_range(15));
                r_len = 8'($urandom_range(4));
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
